// File: rtl/csr_trap_unit_if.sv
// Request/response bundle between decode/execute and the machine-mode CSR/trap unit.
// master: upstream pipeline stage; slave: csr_trap_unit.
interface csr_trap_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic [31:0]     req_inst;
  logic [XLEN-1:0] req_rs1;
  logic            req_expt_valid;
  logic [XLEN-1:0] req_expt_cause;
  logic [XLEN-1:0] req_expt_value;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output req_valid, req_pc, req_inst, req_rs1, req_expt_valid, req_expt_cause,
           req_expt_value,
    input  req_ready, rsp_valid, rsp_rdata, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_pc, req_inst, req_rs1, req_expt_valid, req_expt_cause,
           req_expt_value,
    output req_ready, rsp_valid, rsp_rdata, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file (mtvec, mepc, mcause, mtval) and trap/MRET sequencer.
// Two-state handshake: accept in IDLE, respond for one cycle in BUSY.
// Optional feature: define CSR_MCYCLE_EN to add a free-running 64-bit mcycle at 0xB00.
module csr_trap_unit #(
  parameter int unsigned XLEN = 64
) (
  input logic            clk,
  input logic            rst_n,
  csr_trap_unit_if.slave bus
);

  localparam logic [0:0]  StIdle     = 1'b0;
  localparam logic [0:0]  StBusy     = 1'b1;
  localparam logic [6:0]  OpSystem   = 7'h73;
  localparam logic [31:0] InstEcall  = 32'h0000_0073;
  localparam logic [31:0] InstEbreak = 32'h0010_0073;
  localparam logic [31:0] InstMret   = 32'h3020_0073;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;
`ifdef CSR_MCYCLE_EN
  localparam logic [11:0] CsrMcycle  = 12'hB00;
`endif
  localparam logic [XLEN-1:0] CauseIllegal = XLEN'(2);
  localparam logic [XLEN-1:0] CauseBreak   = XLEN'(3);
  localparam logic [XLEN-1:0] CauseEcallM  = XLEN'(11);

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, rs1_q, expt_cause_q, expt_value_q;
  logic [31:0]     inst_q;
  logic            expt_valid_q;
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mtval_q;
`ifdef CSR_MCYCLE_EN
  logic [63:0]     mcycle_q;
`endif

  logic            accept, busy;
  logic [2:0]      funct3;
  logic [11:0]     csr_addr;
  logic [4:0]      uimm;
  logic            csr_impl, is_trap, is_mret, is_csr, csr_wr_en;
  logic [XLEN-1:0] csr_old, operand, csr_wdata, trap_cause, trap_value;

  assign bus.req_ready = (state_q == StIdle) && rst_n;
  assign accept        = bus.req_valid && bus.req_ready;
  assign busy          = (state_q == StBusy);
  assign funct3        = inst_q[14:12];
  assign csr_addr      = inst_q[31:20];
  assign uimm          = inst_q[19:15];

  // Next-state: IDLE -> BUSY on acceptance, BUSY always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      default: state_d = StIdle;
    endcase
  end

  // State and captured request; upstream may drop req_* right after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      inst_q       <= '0;
      rs1_q        <= '0;
      expt_valid_q <= 1'b0;
      expt_cause_q <= '0;
      expt_value_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q         <= bus.req_pc;
        inst_q       <= bus.req_inst;
        rs1_q        <= bus.req_rs1;
        expt_valid_q <= bus.req_expt_valid;
        expt_cause_q <= bus.req_expt_cause;
        expt_value_q <= bus.req_expt_value;
      end
    end
  end

  // CSR read mux and prioritised decode of the captured instruction.
  always_comb begin
    csr_impl   = 1'b0;
    csr_old    = '0;
    is_trap    = 1'b0;
    is_mret    = 1'b0;
    is_csr     = 1'b0;
    trap_cause = '0;
    trap_value = '0;
    case (csr_addr)
      CsrMtvec:  begin csr_impl = 1'b1; csr_old = mtvec_q;  end
      CsrMepc:   begin csr_impl = 1'b1; csr_old = mepc_q;   end
      CsrMcause: begin csr_impl = 1'b1; csr_old = mcause_q; end
      CsrMtval:  begin csr_impl = 1'b1; csr_old = mtval_q;  end
`ifdef CSR_MCYCLE_EN
      CsrMcycle: begin csr_impl = 1'b1; csr_old = XLEN'(mcycle_q); end
`endif
      default: ;
    endcase
    if (expt_valid_q) begin
      is_trap    = 1'b1;
      trap_cause = expt_cause_q;
      trap_value = expt_value_q;
    end else if (inst_q[6:0] != OpSystem) begin
      // Non-SYSTEM opcodes complete as a silent no-op.
    end else if (inst_q == InstEcall) begin
      is_trap    = 1'b1;
      trap_cause = CauseEcallM;
    end else if (inst_q == InstEbreak) begin
      is_trap    = 1'b1;
      trap_cause = CauseBreak;
      trap_value = pc_q;
    end else if (inst_q == InstMret) begin
      is_mret = 1'b1;
    end else if ((funct3 == 3'b000) || (funct3 == 3'b100) || !csr_impl) begin
      is_trap    = 1'b1;
      trap_cause = CauseIllegal;
      trap_value = XLEN'(inst_q);
    end else begin
      is_csr = 1'b1;
    end
  end

  // Zicsr write data; set/clear with a zero rs1/uimm field leaves the CSR untouched.
  always_comb begin
    operand   = funct3[2] ? XLEN'(uimm) : rs1_q;
    csr_wdata = operand;
    case (funct3[1:0])
      2'b10:   csr_wdata = csr_old | operand;
      2'b11:   csr_wdata = csr_old & ~operand;
      default: csr_wdata = operand;
    endcase
    csr_wr_en = is_csr && ((funct3[1:0] == 2'b01) || (uimm != 5'd0));
  end

  // Architectural CSR update at the end of BUSY; a trap suppresses the instruction's write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (busy) begin
      if (is_trap) begin
        mepc_q   <= {pc_q[XLEN-1:2], 2'b00};
        mcause_q <= trap_cause;
        mtval_q  <= trap_value;
      end else if (csr_wr_en) begin
        case (csr_addr)
          CsrMtvec:  mtvec_q  <= {csr_wdata[XLEN-1:2], 2'b00};
          CsrMepc:   mepc_q   <= {csr_wdata[XLEN-1:2], 2'b00};
          CsrMcause: mcause_q <= csr_wdata;
          CsrMtval:  mtval_q  <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_MCYCLE_EN
  // Free-running cycle counter; an explicit write replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q <= '0;
    end else if (busy && csr_wr_en && (csr_addr == CsrMcycle)) begin
      mcycle_q <= 64'(csr_wdata);
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end
`endif

  assign bus.rsp_valid      = busy;
  assign bus.rsp_rdata      = (busy && is_csr) ? csr_old : '0;
  assign bus.redirect_valid = busy && (is_trap || is_mret);

  // Redirect target: trap vector or saved return PC, zero when idle.
  always_comb begin
    bus.redirect_pc = '0;
    if (busy && is_trap)      bus.redirect_pc = mtvec_q;
    else if (busy && is_mret) bus.redirect_pc = mepc_q;
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit with a cycle-level reference model.
// Build with +define+CSR_MCYCLE_EN to exercise the optional mcycle counter.
module tb_csr_trap_unit;
  localparam int unsigned XLEN = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csr_trap_unit_if #(.XLEN(XLEN)) bus ();

  csr_trap_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Reference model state: CSRs by address; presence in the map means "implemented".
  logic [63:0] m_csr [logic [11:0]];
  bit          m_busy;
  logic [63:0] exp_rdata, exp_rpc;
  bit          exp_rv;
  bit          p_trap, p_wr;
  logic [63:0] p_pc, p_cause, p_val, p_wdata;
  logic [11:0] p_addr;

  // Last response seen on the bus, for hand-computed literal checks.
  logic [63:0] obs_rdata, obs_rpc;
  logic        obs_rv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] csr_i(input logic [2:0] f3, input logic [11:0] a,
                                        input logic [4:0] fld, input logic [4:0] rd);
    return {a, fld, f3, rd, 7'h73};
  endfunction

  task automatic model_reset();
    m_csr.delete();
    m_csr[12'h305] = '0;
    m_csr[12'h341] = '0;
    m_csr[12'h342] = '0;
    m_csr[12'h343] = '0;
`ifdef CSR_MCYCLE_EN
    m_csr[12'hB00] = '0;
`endif
    m_busy = 0; exp_rv = 0; exp_rdata = '0; exp_rpc = '0;
    p_trap = 0; p_wr = 0;
  endtask

  task automatic take_trap(input logic [63:0] cause, input logic [63:0] val);
    p_trap  = 1;
    p_cause = cause;
    p_val   = val;
    exp_rv  = 1;
    exp_rpc = m_csr[12'h305];
  endtask

  // What the unit must do with the request on the bus at an accepting edge.
  task automatic accept();
    logic [31:0] inst;
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  fld;
    logic [63:0] old, opnd;
    inst = bus.req_inst;
    f3   = inst[14:12];
    a    = inst[31:20];
    fld  = inst[19:15];
    m_busy = 1; exp_rv = 0; exp_rdata = '0; exp_rpc = '0;
    p_trap = 0; p_wr = 0; p_pc = bus.req_pc;
    if (bus.req_expt_valid) take_trap(bus.req_expt_cause, bus.req_expt_value);
    else if (inst[6:0] != 7'h73) begin end
    else if (inst == 32'h0000_0073) take_trap(64'd11, 64'd0);
    else if (inst == 32'h0010_0073) take_trap(64'd3, bus.req_pc);
    else if (inst == 32'h3020_0073) begin
      exp_rv  = 1;
      exp_rpc = m_csr[12'h341];
    end else if (f3 == 3'd0 || f3 == 3'd4 || !m_csr.exists(a)) take_trap(64'd2, {32'd0, inst});
    else begin
      old       = m_csr[a];
      exp_rdata = old;
      opnd      = f3[2] ? {59'd0, fld} : bus.req_rs1;
      if (f3[1:0] == 2'b01)      p_wdata = opnd;
      else if (f3[1:0] == 2'b10) p_wdata = old | opnd;
      else                       p_wdata = old & ~opnd;
      p_wr   = (f3[1:0] == 2'b01) || (fld != 5'd0);
      p_addr = a;
    end
  endtask

  // One clock edge: advance the model exactly as the spec says the edge should.
  task automatic tick();
    logic [63:0] v;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
`ifdef CSR_MCYCLE_EN
      m_csr[12'hB00] = m_csr[12'hB00] + 64'd1;
`endif
      if (m_busy) begin
        if (p_trap) begin
          m_csr[12'h341] = p_pc & ~64'h3;
          m_csr[12'h342] = p_cause;
          m_csr[12'h343] = p_val;
        end else if (p_wr) begin
          v = p_wdata;
          if (p_addr == 12'h305 || p_addr == 12'h341) v = v & ~64'h3;
          m_csr[p_addr] = v;
        end
        m_busy = 0; exp_rv = 0; exp_rdata = '0; exp_rpc = '0;
      end else if (bus.req_valid) begin
        accept();
      end
    end
  endtask

  // Compare every output against the model on each falling edge.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("req_ready", {63'd0, bus.req_ready}, {63'd0, (!m_busy && rst_n)});
        check("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, m_busy});
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("redirect_valid", {63'd0, bus.redirect_valid}, {63'd0, exp_rv});
        check("redirect_pc", bus.redirect_pc, exp_rpc);
        if (bus.rsp_valid) begin
          obs_rdata = bus.rsp_rdata;
          obs_rv    = bus.redirect_valid;
          obs_rpc   = bus.redirect_pc;
        end
      end
    end
  endtask

  task automatic send(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] rs1,
                      input logic ev = 1'b0, input logic [63:0] ec = '0,
                      input logic [63:0] evl = '0, input bit keep = 1'b0);
    bus.req_pc = pc; bus.req_inst = inst; bus.req_rs1 = rs1;
    bus.req_expt_valid = ev; bus.req_expt_cause = ec; bus.req_expt_value = evl;
    bus.req_valid = 1'b1;
    tick();
    if (!keep) begin
      // Scramble the request to show the unit works from its captured copy.
      bus.req_valid = 1'b0; bus.req_rs1 = '1; bus.req_pc = '1; bus.req_inst = '1;
      bus.req_expt_valid = 1'b1; bus.req_expt_cause = '1; bus.req_expt_value = '1;
    end
    tick();
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [63:0] expv);
    send(64'h8000, csr_i(3'b010, a, 5'd0, 5'd1), '0);
    check(name, obs_rdata, expv);
  endtask

  initial begin
    fork
      compare_loop();
    join_none
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_pc = '0; bus.req_inst = '0; bus.req_rs1 = '0;
    bus.req_expt_valid = 1'b0; bus.req_expt_cause = '0; bus.req_expt_value = '0;
    model_reset();
    tick();
    cmp_en = 1'b1;
    tick();
    rst_n = 1'b1;

`ifdef CSR_MCYCLE_EN
    repeat (9) tick();
    send('0, csr_i(3'b010, 12'hB00, 5'd0, 5'd1), '0);
    check("mcycle_after_reset", {63'd0, (obs_rdata == 64'd9 || obs_rdata == 64'd10)}, 64'd1);
    send('0, csr_i(3'b001, 12'hB00, 5'd2, 5'd0), 64'd5);
    rd_chk("mcycle_write", 12'hB00, 64'd6);
`endif

    send(64'h1000, csr_i(3'b001, 12'h305, 5'd1, 5'd5), 64'h8000_0003);
    check("csrrw_old", obs_rdata, 64'd0);
    rd_chk("mtvec_masked", 12'h305, 64'h8000_0000);
    send(64'h1008, csr_i(3'b001, 12'h305, 5'd1, 5'd0), 64'h100);

    send(64'h2000, 32'h0000_0073, '0);
    check("ecall_redir_v", {63'd0, obs_rv}, 64'd1);
    check("ecall_redir_pc", obs_rpc, 64'h100);
    check("ecall_rdata", obs_rdata, 64'd0);
    send(64'h2004, 32'h3020_0073, '0);
    check("mret_pc", obs_rpc, 64'h2000);
    rd_chk("mepc_ecall", 12'h341, 64'h2000);
    rd_chk("mcause_ecall", 12'h342, 64'd11);
    rd_chk("mtval_ecall", 12'h343, 64'd0);

    send(64'h3006, 32'h0010_0073, '0);
    check("ebreak_pc", obs_rpc, 64'h100);
    rd_chk("mepc_ebreak", 12'h341, 64'h3004);
    rd_chk("mtval_ebreak", 12'h343, 64'h3006);
    rd_chk("mcause_ebreak", 12'h342, 64'd3);

    send(64'h4000, 32'h7C00_A073, 64'hFFFF);
    check("unimpl_redir_v", {63'd0, obs_rv}, 64'd1);
    rd_chk("mcause_unimpl", 12'h342, 64'd2);
    rd_chk("mtval_unimpl", 12'h343, 64'h7C00_A073);

    send(64'h5000, csr_i(3'b001, 12'h341, 5'd7, 5'd0), 64'hDEAD_BEE0, 1'b1, 64'd4, 64'h13);
    check("expt_redir_pc", obs_rpc, 64'h100);
    rd_chk("mepc_expt", 12'h341, 64'h5000);
    rd_chk("mtval_expt", 12'h343, 64'h13);
    rd_chk("mcause_expt", 12'h342, 64'd4);

    send(64'h5100, csr_i(3'b010, 12'h343, 5'd3, 5'd1), 64'hF0);
    check("csrrs_old", obs_rdata, 64'h13);
    rd_chk("mtval_rs", 12'h343, 64'hF3);
    send(64'h5104, csr_i(3'b011, 12'h343, 5'd3, 5'd1), 64'h3);
    rd_chk("mtval_rc", 12'h343, 64'hF0);
    send(64'h5108, csr_i(3'b010, 12'h343, 5'd0, 5'd1), 64'hFFFF);
    rd_chk("mtval_rs_x0", 12'h343, 64'hF0);
    send(64'h510C, csr_i(3'b101, 12'h305, 5'h1F, 5'd1), '0);
    rd_chk("mtvec_rwi", 12'h305, 64'h1C);
    send(64'h5110, csr_i(3'b111, 12'h305, 5'd4, 5'd1), '0);
    rd_chk("mtvec_rci", 12'h305, 64'h18);
    send(64'h5114, csr_i(3'b110, 12'h342, 5'd0, 5'd1), '0);
    rd_chk("mcause_rsi0", 12'h342, 64'd4);

    send(64'h5200, 32'h00A0_0093, 64'h55);
    check("noop_rdata", obs_rdata, 64'd0);
    check("noop_redir", {63'd0, obs_rv}, 64'd0);

    send(64'h6000, csr_i(3'b100, 12'h305, 5'd0, 5'd1), '0);
    check("f3_100_pc", obs_rpc, 64'h18);
    rd_chk("mcause_f3_100", 12'h342, 64'd2);
    send(64'h6004, 32'h1050_0073, '0);
    rd_chk("mtval_wfi", 12'h343, 64'h1050_0073);
`ifndef CSR_MCYCLE_EN
    send(64'h6008, csr_i(3'b010, 12'hB00, 5'd0, 5'd1), '0);
    check("mcycle_absent", {63'd0, obs_rv}, 64'd1);
    rd_chk("mcause_mcycle", 12'h342, 64'd2);
`endif

    // req_valid held high across back-to-back requests; write then dependent read.
    send(64'h7000, csr_i(3'b001, 12'h341, 5'd9, 5'd0), 64'h7777, 1'b0, '0, '0, 1'b1);
    send(64'h7004, csr_i(3'b010, 12'h341, 5'd0, 5'd2), '0, 1'b0, '0, '0, 1'b1);
    check("b2b_mepc", obs_rdata, 64'h7774);
    send(64'h7008, csr_i(3'b010, 12'h305, 5'd0, 5'd2), '0, 1'b0, '0, '0, 1'b1);
    check("b2b_mtvec", obs_rdata, 64'h18);
    bus.req_valid = 1'b0;
    tick();

    // Reset lands while a write is in flight.
    bus.req_inst = csr_i(3'b001, 12'h305, 5'd1, 5'd0);
    bus.req_rs1 = 64'h200; bus.req_expt_valid = 1'b0; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_busy_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    rst_n = 1'b1;
    tick();
    rd_chk("mtvec_after_rst", 12'h305, 64'd0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR and trap sequencer sitting directly downstream of decode/execute, consuming the `eei` package types, opcodes, `CsrAddr` and `CsrCause` encodings. It executes Zicsr instructions on `mtvec`, `mepc`, `mcause` and `mtval`. It converts ECALL, EBREAK, illegal instructions and upstream-flagged exceptions into traps, and resolves MRET. It returns CSR read data and a PC redirect to the fetch stage through a two-state handshake.

## Interface
- `XLEN`, default `eei::XLEN` (64): CSR and data width.
- `clk` in 1: clock; everything is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_pc` in XLEN: PC of the instruction.
- `req_inst` in 32: instruction word (`eei::Inst`).
- `req_rs1` in XLEN: rs1 register value.
- `req_expt_valid` in 1: upstream exception, e.g. misaligned load/store.
- `req_expt_cause` in XLEN: `CsrCause` value for the upstream exception.
- `req_expt_value` in XLEN: mtval for the upstream exception.
- `rsp_valid` out 1: one-cycle result strobe.
- `rsp_rdata` out XLEN: old CSR value destined for rd.
- `redirect_valid` out 1: PC redirect, qualified by `rsp_valid`.
- `redirect_pc` out XLEN: redirect target.

## Operation
- Handshake: a request is accepted when `req_valid && req_ready`. All request fields are captured in registers on acceptance.
- `req_ready = (state == IDLE) && rst_n`.
- FSM states:
  - IDLE: moves to BUSY on acceptance.
  - BUSY: always returns to IDLE after one cycle.
- Decode fields: funct3 = `inst[14:12]`, csr = `inst[31:20]`, rs1 field / uimm = `inst[19:15]`. An opcode other than `OP_SYSTEM` is treated as a no-op CSR access: rdata 0, no write, no redirect.
- Decode priority, highest first:
  1. `req_expt_valid`: trap with the given cause and value.
  2. `0x00000073`: trap, cause 11, mtval 0.
  3. `0x00100073`: trap, cause 3, mtval = pc.
  4. `0x30200073`: MRET.
  5. funct3 000 (other than the three encodings above), funct3 100, or an unimplemented csr address: trap, cause 2, mtval = inst.
  6. Otherwise: CSR operation.
- CSR operation:
  - Source operand is `req_rs1` for funct3 001/010/011 and the zero-extended uimm for 101/110/111.
  - RW writes the operand.
  - RS writes old | operand.
  - RC writes old & ~operand.
  - RS/RC/RSI/RCI with rs1/uimm field = 0 perform no write.
  - RW always writes.
- Write masking:
  - `mtvec[1:0]` and `mepc[1:0]` are forced to 0, giving direct mode and 4-byte alignment.
  - `mcause` and `mtval` are written at full width.
- Trap:
  - `mepc <= pc` with bits [1:0] cleared; `mcause <= cause`; `mtval <= value`.
  - `redirect_pc = mtvec`, `rsp_rdata = 0`.
  - Any CSR write from the same instruction is suppressed.
- MRET: `redirect_pc = mepc`, `rsp_rdata = 0`, no CSR change.

## Timing
- Reset:
  - All CSRs are 0, state is IDLE.
  - `rsp_valid`, `redirect_valid`, `rsp_rdata` and `redirect_pc` are 0.
  - `req_ready` is 0 while `rst_n` is low.
- Latency:
  - Request accepted at edge N.
  - In cycle N→N+1 (BUSY), `rsp_valid = 1` and the outputs are valid. `rsp_rdata` carries the pre-write value.
  - CSR updates take effect at edge N+1.
  - The next request can be accepted at edge N+2. Throughput is one request per 2 cycles.
- Outputs are combinational from the BUSY-state registers and the CSR registers. They are 0 in IDLE.
- Back-to-back dependency: a read in the request after a write sees the written value, because the write lands before the next BUSY.
- Upstream is not required to hold `req_*` after acceptance.
- Reset asserted during BUSY:
  - The next edge returns to IDLE.
  - The in-flight CSR write or trap update is discarded, because reset has priority.
  - `rsp_valid` is low from the following cycle.

## Configuration
- `CSR_MCYCLE_EN` defined:
  - Adds a 64-bit `mcycle` at 0xB00.
  - It increments every cycle while `rst_n` is high and resets to 0.
  - A CSR write to it in BUSY replaces that cycle's increment with the written value.
  - Reads return the pre-increment value.
- `CSR_MCYCLE_EN` undefined: 0xB00 is unimplemented, so any access traps with illegal instruction, cause 2.

## Test plan
- Reset, then CSRRW x5 with rs1 = 0x8000_0003 to `mtvec` (0x305) -> `rsp_rdata` = 0. A following CSRRS x0 read of `mtvec` -> 0x8000_0000.
- `mtvec` = 0x100, ECALL at pc 0x2000 -> `redirect_valid`, `redirect_pc` = 0x100. `mepc` = 0x2000, `mcause` = 11, `mtval` = 0.
- Then MRET -> `redirect_pc` = 0x2000, and CSRs are unchanged.
- CSRRS to csr 0x7C0 with inst 0x7C0_0A073 -> trap, `mcause` = 2, `mtval` = 0x7C00A073, no CSR write.
- `req_expt_valid` with cause 4, value 0x13, on a CSRRW to `mepc` -> trap; `mepc` = pc and `mtval` = 0x13. The CSRRW write is suppressed.
- `req_valid` held high continuously -> `req_ready` alternates 1/0. Asserting `rst_n` low during BUSY -> no CSR update and `rsp_valid` = 0 next cycle. With `CSR_MCYCLE_EN`, read 0xB00 10 cycles after reset -> 9 or 10 consistent with acceptance edge; the write value 5 reads back 5+k.
